// File: rtl/pea_pkg.sv
// rtl/pea_pkg.sv - shared encodings, FSM states and helpers for the PEA enable scheduler
package pea_pkg;

    // next_mode_in encodings; 2 and 3 are reserved
    localparam logic [1:0] NM_SETUP_INSTR = 2'd0;
    localparam logic [1:0] NM_INSTR       = 2'd1;

    // instruction mode encodings; all other values are illegal
    localparam logic [7:0] MODE_STP = 8'd0;
    localparam logic [7:0] MODE_EVP = 8'd1;
    localparam logic [7:0] MODE_EVB = 8'd2;
    localparam logic [7:0] MODE_RST = 8'd3;

    typedef enum logic [1:0] {
        ST_EVAL   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // ceil(log2(value)); exact for the power-of-two depths used here
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pea_fifo_occupancy.sv
// rtl/pea_fifo_occupancy.sv - wrap-bit FIFO occupancy and pointer-corruption detect
//
// Ports:
//   wr_ptr_i  - write pointer, wrap bit in MSB
//   rd_ptr_i  - read pointer, wrap bit in MSB
//   occ_o     - (wr - rd) modulo 2^ptr_w
//   ptr_err_o - occupancy exceeds buffer_size, pointers cannot be valid
module pea_fifo_occupancy
    import pea_pkg::*;
#(
    parameter  int buffer_size = 1024,
    localparam int ptr_w       = log2(buffer_size) + 1
) (
    input  logic [ptr_w-1:0] wr_ptr_i,
    input  logic [ptr_w-1:0] rd_ptr_i,
    output logic [ptr_w-1:0] occ_o,
    output logic             ptr_err_o
);

    localparam logic [ptr_w-1:0] full_occ = ptr_w'(buffer_size);

    // The extra wrap bit makes full (occ == buffer_size) distinct from empty;
    // the subtraction wraps naturally at ptr_w bits.
    assign occ_o     = wr_ptr_i - rd_ptr_i;
    assign ptr_err_o = (occ_o > full_occ);

endmodule

// File: rtl/pea_enable_sched.sv
// rtl/pea_enable_sched.sv - registered, handshaked firing-rule scheduler for the PEA core
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   next_mode_in, mode, arg2        - selects the next firing and its token count
//   wr/rd_ptr_command, wr/rd_ptr_data - FIFO pointers with wrap bit
//   result_free_space, status_free_space - free slots in the output FIFOs
//   invoke, done                    - core handshake
//   enable                          - registered firing permission
//   busy                            - firing in progress or pointers settling
//   fire_count                      - accepted invocations, wrapping
//   protocol_err                    - sticky handshake / pointer error
module pea_enable_sched
    import pea_pkg::*;
#(
    parameter  int buffer_size  = 1024,
    parameter  int arg_w        = 5,
    parameter  int check_output = 1,
    parameter  int cnt_w        = 16,
    localparam int ptr_w        = log2(buffer_size) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       next_mode_in,
    input  logic [7:0]       mode,
    input  logic [arg_w-1:0] arg2,
    input  logic [ptr_w-1:0] wr_ptr_command,
    input  logic [ptr_w-1:0] rd_ptr_command,
    input  logic [ptr_w-1:0] wr_ptr_data,
    input  logic [ptr_w-1:0] rd_ptr_data,
    input  logic [ptr_w-1:0] result_free_space,
    input  logic [ptr_w-1:0] status_free_space,
    input  logic             invoke,
    input  logic             done,
    output logic             enable,
    output logic             busy,
    output logic [cnt_w-1:0] fire_count,
    output logic             protocol_err
);

    localparam logic             chk_out = (check_output != 0);
    localparam logic [ptr_w-1:0] one     = ptr_w'(1);

    logic [ptr_w-1:0] cmd_occ;
    logic [ptr_w-1:0] data_occ;
    logic             cmd_err;
    logic             data_err;
    logic [ptr_w-1:0] arg_ext;
    logic             rule;

    state_e           state_q, state_d;
    logic             enable_q, enable_d;
    logic [cnt_w-1:0] fire_count_q, fire_count_d;
    logic             perr_q, perr_d;
    logic             accept;

    pea_fifo_occupancy #(.buffer_size(buffer_size)) u_cmd_occ (
        .wr_ptr_i  (wr_ptr_command),
        .rd_ptr_i  (rd_ptr_command),
        .occ_o     (cmd_occ),
        .ptr_err_o (cmd_err)
    );

    pea_fifo_occupancy #(.buffer_size(buffer_size)) u_data_occ (
        .wr_ptr_i  (wr_ptr_data),
        .rd_ptr_i  (rd_ptr_data),
        .occ_o     (data_occ),
        .ptr_err_o (data_err)
    );

    assign arg_ext = ptr_w'(arg2);

    // Firing rule. arg2 == 0 needs no special case: unsigned x >= 0 is true.
    always_comb begin
        rule = 1'b0;
        case (next_mode_in)
            NM_SETUP_INSTR: rule = (cmd_occ >= one);
            NM_INSTR: begin
                case (mode)
                    MODE_STP: rule = (data_occ >= arg_ext) &&
                                     (!chk_out || (result_free_space >= one));
                    MODE_EVP: rule = (data_occ >= one) &&
                                     (!chk_out || ((result_free_space >= one) &&
                                                   (status_free_space >= one)));
                    MODE_EVB: rule = (data_occ >= arg_ext) &&
                                     (!chk_out || ((result_free_space >= arg_ext) &&
                                                   (status_free_space >= arg_ext)));
                    MODE_RST: rule = 1'b1;
                    default:  rule = 1'b0;
                endcase
            end
            default: rule = 1'b0;
        endcase
        // Corrupt pointers on either FIFO veto every firing.
        if (cmd_err || data_err) begin
            rule = 1'b0;
        end
    end

    // invoke is judged against the registered enable, never against the live rule.
    assign accept = invoke && enable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EVAL;
            enable_q     <= 1'b0;
            fire_count_q <= '0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            fire_count_q <= fire_count_d;
            perr_q       <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EVAL:   if (accept) state_d = ST_BUSY;
            ST_BUSY:   if (done)   state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_EVAL;
            default:   state_d = ST_EVAL;
        endcase
    end

    // enable only follows the rule while already in EVAL, so the first EVAL
    // cycle after SETTLE still shows 0 and FIFO pointers get a full extra
    // cycle to reflect the finished firing.
    always_comb begin
        enable_d     = (state_q == ST_EVAL) && !accept && rule;
        fire_count_d = accept ? fire_count_q + 1'b1 : fire_count_q;
        perr_d       = perr_q
                     | (invoke && !enable_q)
                     | (done && (state_q != ST_BUSY))
                     | cmd_err | data_err;
        busy         = (state_q != ST_EVAL);
    end

    assign enable       = enable_q;
    assign fire_count   = fire_count_q;
    assign protocol_err = perr_q;

endmodule

// File: doc/pea_enable_sched.md
# pea_enable_sched

Registered, handshaked firing-rule scheduler for the Polynomial Evaluation Accelerator (PEA). It sits between the command/data/result/status FIFOs and the PEA core controller. Every cycle it evaluates whether the next firing (setup or instruction, per mode) has enough input tokens and output space. It then presents a registered `enable`, accepts an `invoke`, and blocks re-enable until the core reports `done` and FIFO pointers have settled. It adds three things to the previous combinational enable logic: wrap-bit pointers that disambiguate full/empty, enforced result/status free-space checks, and an invoke/done protocol with error and firing counters.

## Interface
Parameters:
- `buffer_size`, 1024 — depth of each FIFO; power of two ≥ 2.
- `arg_w`, 5 — width of `arg2`.
- `check_output`, 1 — 1: enforce result/status free-space terms; 0: ignore them (input terms only).
- `cnt_w`, 16 — width of `fire_count`.
- Derived localparam `ptr_w` = log2(`buffer_size`) + 1 — pointer width including the wrap bit.

Ports:
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `next_mode_in` in 2 — 0 = SETUP_INSTR, 1 = INSTR, 2/3 reserved.
- `mode` in 8 — instruction: 0 STP, 1 EVP, 2 EVB, 3 RST, others illegal.
- `arg2` in `arg_w` — token-count argument for STP/EVB.
- `wr_ptr_command`, `rd_ptr_command` in `ptr_w` — command FIFO pointers, wrap bit in MSB.
- `wr_ptr_data`, `rd_ptr_data` in `ptr_w` — data FIFO pointers.
- `result_free_space`, `status_free_space` in `ptr_w` — free slots, 0..`buffer_size`.
- `invoke` in 1 — core starts a firing.
- `done` in 1 — core finished the current firing; single-cycle pulse.
- `enable` out 1 — registered firing permission.
- `busy` out 1 — high in BUSY and SETTLE.
- `fire_count` out `cnt_w` — accepted invocations, wraps modulo 2^`cnt_w`.
- `protocol_err` out 1 — sticky error flag; cleared only by `rst`.

## Operation
- Occupancy per FIFO: occ = (wr − rd) mod 2^`ptr_w`, unsigned. The legal range is 0..`buffer_size`; occ = `buffer_size` means full.
- If either occ > `buffer_size`, the pointers are corrupt: the rule is false and `protocol_err` is set.
- Comparisons are unsigned, with `arg2` zero-extended to `ptr_w`.
- Rule R, evaluated combinationally (O = `check_output`):
  - SETUP_INSTR: cmd_occ ≥ 1.
  - INSTR/STP: data_occ ≥ arg2 && (!O || result_free ≥ 1).
  - INSTR/EVP: data_occ ≥ 1 && (!O || (result_free ≥ 1 && status_free ≥ 1)).
  - INSTR/EVB: data_occ ≥ arg2 && (!O || (result_free ≥ arg2 && status_free ≥ arg2)).
  - INSTR/RST: 1.
  - Illegal mode or reserved `next_mode_in`: 0.
  - `arg2` = 0 makes the corresponding count term true.
- State machine:
  - EVAL: `enable` ← R each cycle. `invoke` && `enable` → BUSY; `enable` ← 0; `fire_count` +1.
  - BUSY: `enable` = 0. `done` → SETTLE.
  - SETTLE: `enable` = 0 for exactly one cycle, so FIFO pointers can update. Then → EVAL.
- `invoke` while `enable` = 0 (any state) is ignored and sets `protocol_err`.
- `done` outside BUSY is ignored and sets `protocol_err`.
- `invoke` and `done` in the same cycle in BUSY: `done` is taken (→ SETTLE); `invoke` is flagged as an error.
- Reset values: state EVAL, `enable` 0, `busy` 0, `fire_count` 0, `protocol_err` 0.
- `rst` mid-firing abandons BUSY/SETTLE immediately.

## Timing
- Rule-to-enable latency is 1 cycle: inputs at edge t produce `enable` valid after edge t+1.
- `invoke` is sampled against the registered `enable` of the same cycle, never against R.
- After accepted `invoke` at edge t: `enable` = 0 and `busy` = 1 from t+1.
- `done` at edge d: SETTLE during d+1. Earliest `enable` = 1 is after edge d+2.
- Minimum invoke-to-invoke spacing is 4 cycles (done in the cycle after invoke).
- `fire_count` updates on the same edge as the accepting `invoke`. Wrap from 2^`cnt_w`−1 to 0 is silent.

## Structure
- Shared package `pea_pkg` holds:
  - `next_mode_in` encodings (SETUP_INSTR, INSTR);
  - mode constants (STP, EVP, EVB, RST);
  - the FSM state encoding (EVAL, BUSY, SETTLE);
  - the `log2` function.
- Sub-module `pea_fifo_occupancy` (parameter `buffer_size`) computes occ and a `ptr_err` flag. It is instantiated twice (command, data).
- The rule mux, FSM and counters live in the top.

## Test plan
- Reset, then SETUP_INSTR with wr_cmd = 0, rd_cmd = 0 → `enable` 0. Set wr_cmd = 1 → `enable` 1 one cycle later.
- Full FIFO with wrap (buffer_size 1024): wr_data = 1024, rd_data = 0 → occ 1024. INSTR/EVB with arg2 = 31 and free spaces 31 → `enable` 1. result_free = 30 → 0. Repeat with `check_output` = 0 → 1.
- Pointer wrap: wr_data = 3, rd_data = 2045 (ptr_w 11) → occ 6. STP arg2 = 6 → 1; arg2 = 7 → 0.
- Handshake: `invoke` at enable 1 → `busy` 1, `enable` 0, `fire_count` 1. `done` 2 cycles later → SETTLE. `enable` returns 1 exactly 2 edges after `done`.
- Errors: `invoke` with `enable` 0 → `protocol_err` 1, `fire_count` unchanged. `done` in EVAL → `protocol_err` stays 1. wr − rd = 1500 → `enable` 0 and `protocol_err` 1.
- `rst` asserted in BUSY → next cycle state EVAL, all outputs 0. Illegal mode 8'd7 with full FIFOs → `enable` 0.
